// File: rtl/branch_redirect_controller.sv
// branch_redirect_controller: mispredict/misaligned-target redirect sequencing with saturating perf counters
module branch_redirect_controller #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32,
    parameter int CNT_W  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_resolve_valid,
    input  logic [XLEN-1:0] i_resolve_pc,
    input  logic            i_resolve_is_compressed,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_predicted_taken,
    input  logic [XLEN-1:0] i_predicted_target,
    input  logic            i_flush_external,
    input  logic            i_redirect_ready,
    input  logic            i_counter_clear,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic            o_trap_valid,
    output logic [XLEN-1:0] o_trap_tval,
    output logic [31:0]     o_branch_count,
    output logic [31:0]     o_mispredict_count
);
    typedef enum logic {IDLE, REDIRECT_WAIT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state;
    logic accept, misaligned, mispredict;
    logic [XLEN-1:0] next_pc;
    logic [CNT_W-1:0] branch_cnt, mispredict_cnt;
    always_comb begin
        accept = state == IDLE && i_resolve_valid && !i_flush_external;
        misaligned = IALIGN == 32 && i_branch_taken && i_branch_target[1];
        mispredict = i_branch_taken != i_predicted_taken || (i_branch_taken && i_branch_target != i_predicted_target);
        next_pc = i_branch_taken ? i_branch_target : i_resolve_pc + (i_resolve_is_compressed ? XLEN'(2) : XLEN'(4));
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            o_redirect_valid <= 1'b0;
            o_redirect_pc <= '0;
            o_flush <= 1'b0;
            o_trap_valid <= 1'b0;
            o_trap_tval <= '0;
            branch_cnt <= '0;
            mispredict_cnt <= '0;
        end else begin
            o_flush <= 1'b0;
            o_trap_valid <= 1'b0;
            if (state == REDIRECT_WAIT) begin
                if (i_flush_external || i_redirect_ready) begin
                    state <= IDLE;
                    o_redirect_valid <= 1'b0;
                end
            end else if (accept) begin
                if (misaligned) begin
                    o_trap_valid <= 1'b1;
                    o_flush <= 1'b1;
                    o_trap_tval <= i_branch_target;
                end else if (mispredict) begin
                    o_redirect_pc <= next_pc;
                    o_redirect_valid <= 1'b1;
                    o_flush <= 1'b1;
                    state <= REDIRECT_WAIT;
                end
            end
            if (i_counter_clear) branch_cnt <= '0;
            else if (accept && branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
            if (i_counter_clear) mispredict_cnt <= '0;
            else if (accept && mispredict && !misaligned && mispredict_cnt != CNT_MAX) mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end
    assign o_branch_count = 32'(branch_cnt);
    assign o_mispredict_count = 32'(mispredict_cnt);
endmodule

// File: tb/tb_branch_redirect_controller.sv
// tb_branch_redirect_controller: scoreboard bench, IALIGN=32 full-width and IALIGN=16 narrow-counter instances
module tb_branch_redirect_controller;
    typedef struct packed {
        logic        rv;
        logic [31:0] rpc;
        logic        flush;
        logic        trap;
        logic [31:0] tval;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0;
    logic valid, comp, tk, ptk, fext, rdy, clr;
    logic [31:0] pc, tgt, ptgt;
    logic a_rv, a_flush, a_trap, b_rv, b_flush, b_trap;
    logic [31:0] a_rpc, a_tval, a_bc, a_mc, b_rpc, b_tval, b_bc, b_mc;
    exp_t m[2];
    logic mw[2];
    exp_t qa[$], qb[$];
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    branch_redirect_controller dut_a (
        .i_clk(clk), .i_rst(rst), .i_resolve_valid(valid), .i_resolve_pc(pc),
        .i_resolve_is_compressed(comp), .i_branch_taken(tk), .i_branch_target(tgt),
        .i_predicted_taken(ptk), .i_predicted_target(ptgt), .i_flush_external(fext),
        .i_redirect_ready(rdy), .i_counter_clear(clr), .o_redirect_valid(a_rv),
        .o_redirect_pc(a_rpc), .o_flush(a_flush), .o_trap_valid(a_trap), .o_trap_tval(a_tval),
        .o_branch_count(a_bc), .o_mispredict_count(a_mc)
    );
    branch_redirect_controller #(.IALIGN(16), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_resolve_valid(valid), .i_resolve_pc(pc),
        .i_resolve_is_compressed(comp), .i_branch_taken(tk), .i_branch_target(tgt),
        .i_predicted_taken(ptk), .i_predicted_target(ptgt), .i_flush_external(fext),
        .i_redirect_ready(rdy), .i_counter_clear(clr), .o_redirect_valid(b_rv),
        .o_redirect_pc(b_rpc), .o_flush(b_flush), .o_trap_valid(b_trap), .o_trap_tval(b_tval),
        .o_branch_count(b_bc), .o_mispredict_count(b_mc)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic exp_t obs_a();
        return '{a_rv, a_rpc, a_flush, a_trap, a_tval, a_bc, a_mc};
    endfunction
    function automatic exp_t obs_b();
        return '{b_rv, b_rpc, b_flush, b_trap, b_tval, b_bc, b_mc};
    endfunction
    task automatic cmp(input string who, input exp_t g, input exp_t e);
        chk({who, ".redirect_valid"}, 32'(g.rv), 32'(e.rv));
        chk({who, ".redirect_pc"}, g.rpc, e.rpc);
        chk({who, ".flush"}, 32'(g.flush), 32'(e.flush));
        chk({who, ".trap_valid"}, 32'(g.trap), 32'(e.trap));
        chk({who, ".trap_tval"}, g.tval, e.tval);
        chk({who, ".branch_count"}, g.bc, e.bc);
        chk({who, ".mispredict_count"}, g.mc, e.mc);
    endtask
    task automatic model_step(input int id, input bit ia16, input logic [31:0] cmax);
        exp_t e;
        logic trp, mis;
        logic [31:0] npc;
        e = m[id];
        e.flush = 1'b0;
        e.trap = 1'b0;
        npc = tk ? tgt : pc + (comp ? 32'd2 : 32'd4);
        trp = !ia16 && tk && tgt[1];
        mis = (tk != ptk) || (tk && ptk && tgt != ptgt);
        if (mw[id]) begin
            if (fext || rdy) begin
                mw[id] = 1'b0;
                e.rv = 1'b0;
            end
        end else if (valid && !fext) begin
            if (e.bc != cmax) e.bc = e.bc + 1;
            if (trp) begin
                e.trap = 1'b1;
                e.flush = 1'b1;
                e.tval = tgt;
            end else if (mis) begin
                e.rv = 1'b1;
                e.rpc = npc;
                e.flush = 1'b1;
                mw[id] = 1'b1;
                if (e.mc != cmax) e.mc = e.mc + 1;
            end
        end
        if (clr) begin
            e.bc = 0;
            e.mc = 0;
        end
        m[id] = e;
        if (id == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask
    task automatic idle_in();
        valid = 0; comp = 0; tk = 0; ptk = 0; fext = 0; rdy = 0; clr = 0;
        pc = 0; tgt = 0; ptgt = 0;
    endtask
    task automatic res(input logic [31:0] p, input logic c, input logic t, input logic [31:0] g,
                       input logic pt, input logic [31:0] pg);
        valid = 1; pc = p; comp = c; tk = t; tgt = g; ptk = pt; ptgt = pg;
    endtask
    task automatic cyc();
        exp_t e;
        model_step(0, 1'b0, 32'hFFFF_FFFF);
        model_step(1, 1'b1, 32'h3);
        @(posedge clk);
        @(negedge clk);
        if (qa.size() == 0 || qb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else begin
            e = qa.pop_front();
            cmp("a", obs_a(), e);
            e = qb.pop_front();
            cmp("b", obs_b(), e);
        end
        idle_in();
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("rst_a", obs_a(), '0);
        cmp("rst_b", obs_b(), '0);
        m[0] = '0; m[1] = '0; mw[0] = 0; mw[1] = 0;
        qa.delete(); qb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        idle_in();
        do_reset();
        res(32'h100, 0, 1, 32'h200, 1, 32'h200); cyc();
        chk("correct.flush", 32'(a_flush), 0);
        chk("correct.bc", a_bc, 1);
        chk("correct.mc", a_mc, 0);
        res(32'h100, 0, 0, 32'h0, 1, 32'h200); cyc();
        chk("nt.flush", 32'(a_flush), 1);
        chk("nt.valid", 32'(a_rv), 1);
        chk("nt.pc", a_rpc, 32'h104);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nt.hold_valid", 32'(a_rv), 1);
            chk("nt.hold_pc", a_rpc, 32'h104);
        end
        rdy = 1; cyc();
        chk("nt.released", 32'(a_rv), 0);
        res(32'h1000, 0, 1, 32'h3000, 1, 32'h2000); cyc();
        chk("jalr.pc", a_rpc, 32'h3000);
        chk("jalr.mc", a_mc, 2);
        res(32'h500, 0, 1, 32'h600, 0, 32'h0); cyc();
        chk("wrongpath.bc", a_bc, 3);
        rdy = 1; cyc();
        res(32'hFFFF_FFFE, 1, 0, 32'h0, 1, 32'h10); cyc();
        chk("wrap.valid", 32'(a_rv), 1);
        chk("wrap.pc", a_rpc, 32'h0);
        rdy = 1; cyc();
        res(32'h400, 0, 1, 32'h402, 1, 32'h400); cyc();
        chk("mis.trap", 32'(a_trap), 1);
        chk("mis.flush", 32'(a_flush), 1);
        chk("mis.tval", a_tval, 32'h402);
        chk("mis.novalid", 32'(a_rv), 0);
        chk("mis.mc", a_mc, 3);
        chk("ia16.valid", 32'(b_rv), 1);
        chk("ia16.pc", b_rpc, 32'h402);
        cyc();
        chk("mis.trap_pulse", 32'(a_trap), 0);
        chk("mis.tval_held", a_tval, 32'h402);
        rdy = 1; cyc();
        res(32'h800, 0, 0, 32'h0, 1, 32'h900); cyc();
        fext = 1; rdy = 1; cyc();
        chk("fext.cancel", 32'(a_rv), 0);
        res(32'h800, 0, 0, 32'h0, 1, 32'h900); fext = 1; cyc();
        chk("fext.ignored_flush", 32'(a_flush), 0);
        chk("fext.ignored_bc", a_bc, 6);
        clr = 1; cyc();
        chk("clr.bc", a_bc, 0);
        for (int i = 0; i < 5; i++) begin
            res(32'h100, 0, 1, 32'h200, 1, 32'h200); cyc();
        end
        chk("sat.b_bc", b_bc, 3);
        chk("sat.a_bc", a_bc, 5);
        res(32'h100, 0, 0, 32'h0, 1, 32'h200); clr = 1; cyc();
        chk("clrwin.bc", a_bc, 0);
        chk("clrwin.mc", a_mc, 0);
        chk("clrwin.flush", 32'(a_flush), 1);
        rdy = 1; cyc();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ts[3];
            ts[0] = 32'h2000; ts[1] = 32'h2002; ts[2] = 32'h3000;
            valid = $urandom_range(0, 3) != 0;
            pc = $urandom;
            comp = 1'($urandom_range(0, 1));
            tk = 1'($urandom_range(0, 1));
            ptk = 1'($urandom_range(0, 1));
            tgt = ts[$urandom_range(0, 2)];
            ptgt = ts[2 * $urandom_range(0, 1)];
            fext = $urandom_range(0, 7) == 0;
            rdy = 1'($urandom_range(0, 1));
            clr = $urandom_range(0, 15) == 0;
            cyc();
        end
        rdy = 1; cyc();
        res(32'h100, 0, 0, 32'h0, 1, 32'h200); cyc();
        chk("prerst.valid", 32'(a_rv), 1);
        do_reset();
        res(32'h200, 1, 0, 32'h0, 1, 32'h300); cyc();
        chk("postrst.pc", a_rpc, 32'h202);
        chk("postrst.bc", a_bc, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_redirect_controller.md
# branch_redirect_controller

Sequences front-end redirection after control-flow resolution in EX. Each cycle it compares the branch/jump unit's resolved outcome (taken flag, target) against the fetch-time prediction carried down the pipe. On a mispredict it issues a one-cycle younger-stage flush and a held valid/ready redirect to the PC controller. It also raises instruction-address-misaligned traps and keeps saturating branch/mispredict counters for performance CSRs.

## Interface
- XLEN, 32: address/data width.
- IALIGN, 32: instruction alignment; 32 = target bit 1 set is misaligned; 16 = never misaligned (C extension present).
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_resolve_valid  in  1  a control-flow instruction (branch, JAL, JALR) resolves in EX this cycle.
- i_resolve_pc  in  XLEN  PC of the resolving instruction.
- i_resolve_is_compressed  in  1  instruction is 16-bit; fall-through = pc+2, else pc+4.
- i_branch_taken  in  1  actual taken outcome from the branch/jump unit.
- i_branch_target  in  XLEN  actual target from the branch/jump unit.
- i_predicted_taken  in  1  fetch-time prediction.
- i_predicted_target  in  XLEN  fetch-time predicted target.
- i_flush_external  in  1  older-instruction flush (trap/interrupt from later stage).
- i_redirect_ready  in  1  PC controller accepts redirect.
- i_counter_clear  in  1  synchronous clear of both counters.
- o_redirect_valid  out  1  redirect request pending.
- o_redirect_pc  out  XLEN  corrected next PC.
- o_flush  out  1  one-cycle pulse: kill IF/ID/EX younger instructions.
- o_trap_valid  out  1  one-cycle pulse: instruction-address-misaligned.
- o_trap_tval  out  XLEN  misaligned target; held until next trap.
- o_branch_count  out  32  accepted resolutions, saturating.
- o_mispredict_count  out  32  detected mispredicts, saturating.

## Operation
- States: IDLE, REDIRECT_WAIT.
- A resolve is accepted only when state = IDLE, i_resolve_valid = 1, and i_flush_external = 0. Resolves in any other cycle are wrong-path and ignored: no counts, no effects.
- Correct next PC: i_branch_taken ? i_branch_target : i_resolve_pc + (compressed ? 2 : 4). Addition wraps modulo 2^XLEN.
- Misaligned: IALIGN = 32, i_branch_taken = 1, and i_branch_target[1] = 1. Trap takes priority over mispredict:
  - pulse o_trap_valid and o_flush;
  - latch o_trap_tval = target;
  - no redirect;
  - branch count increments, mispredict count does not.
- Mispredict: i_branch_taken != i_predicted_taken, or both taken and i_branch_target != i_predicted_target.
- Accepted mispredict:
  - latch o_redirect_pc;
  - next cycle: o_redirect_valid = 1, o_flush = 1 (one cycle);
  - state → REDIRECT_WAIT;
  - mispredict count +1.
- Correct prediction: branch count +1 only, state stays IDLE.
- REDIRECT_WAIT:
  - o_redirect_valid and o_redirect_pc held stable until i_redirect_ready = 1, then → IDLE next cycle.
  - i_flush_external cancels the pending redirect (→ IDLE, valid drops next cycle) even if ready is asserted the same cycle.
- Counters: +1 per event, saturate at 0xFFFFFFFF. i_counter_clear wins over a simultaneous increment.

## Timing
- Reset: state IDLE; all outputs 0, including counters, o_redirect_pc, and o_trap_tval. Reset mid-redirect drops the request.
- All outputs are registered. Resolve accepted at cycle N → o_flush / o_trap_valid / o_redirect_valid visible at N+1.
- Handshake: transfer occurs in the cycle with o_redirect_valid & i_redirect_ready. o_redirect_valid is low from the following cycle.
- Minimum spacing: ready at N+1 → IDLE at N+2 → next resolve accepted at N+2, redirect at N+3.
- o_flush is never high for more than one consecutive cycle per event.
- Counters update at N+1 with the event.

## Test plan
- Correct prediction: pc=0x100, taken=1, target=0x200, pred taken/0x200 → no flush, no redirect; branch_count=1, mispredict_count=0.
- Predicted taken, not taken: pc=0x100, 32-bit, taken=0, pred taken=1 → at N+1: o_flush=1, o_redirect_valid=1, o_redirect_pc=0x104; with ready held low 3 cycles, valid and pc stay stable; ready=1 → valid low the next cycle.
- Wrong target (JALR): taken=1, target=0x3000, pred taken/0x2000 → redirect 0x3000, mispredict_count=1. A resolve presented during REDIRECT_WAIT is ignored (branch_count unchanged). Compressed not-taken at pc=0xFFFFFFFE → redirect 0x00000000 (wrap).
- Misaligned (IALIGN=32): taken=1, target=0x402 → o_trap_valid=1, o_flush=1, o_trap_tval=0x402, no redirect, mispredict_count unchanged. With IALIGN=16 the same stimulus → normal redirect.
- External flush: in REDIRECT_WAIT, i_flush_external=1 with ready=1 → valid drops, IDLE. Flush coincident with a resolve in IDLE → resolve ignored.
- Counters: force branch_count near 0xFFFFFFFF, accept 2 resolves → stays 0xFFFFFFFF. Clear with a simultaneous resolve → 0. Assert i_rst mid-REDIRECT_WAIT → all outputs 0 immediately.
